dat_transfer_control: RTL and testbench
=======================================

Name: dat_transfer_control

Overview:
- Control layer directly upstream of the DAT physical layer.
- Accepts a multi-block transfer request (direction, block count, data timeout) from the host register file and issues one newService_control handshake per block to the physical layer.
- Gates each block on FIFO readiness, counts completed blocks, and reports done, data-timeout, acknowledge-timeout or abort status back to the register file.

Parameters:
- BLKCNT_W, 16, width of block count and blocks-done counter
- TIMEOUT_W, 16, width of the data timeout value passed to the physical layer
- ACK_LIMIT, 8, cycles allowed between newService_control assertion and phy_recibido

Ports:
- SDclock input 1 clock
- reset input 1 sync reset
- start input 1 one-cycle request pulse from register file
- write_read input 1 direction: 1 = host->SD write, 0 = SD->host read
- block_count input BLKCNT_W number of blocks requested
- timeout_in input TIMEOUT_W data timeout value
- timeout_en_in input 1 enables data timeout
- abort input 1 stop request
- fifo_empty input 1 TX FIFO empty
- fifo_full input 1 RX FIFO full
- phy_idle input 1 physical layer IDLE indication
- phy_recibido input 1 physical layer acknowledged service
- phy_complete input 1 physical layer transferComplete
- phy_timeout input 1 physical layer timeOutFail
- newService_control output 1 service request to physical layer
- writeRead_control output 1 latched direction
- timeout output TIMEOUT_W latched timeout
- timeoutenable output 1 latched timeout enable
- busy output 1 transfer in progress
- transfer_done output 1 one-cycle completion pulse
- error_code output 2 00 none, 01 data timeout, 10 ack timeout, 11 aborted
- blocks_done output BLKCNT_W completed block count

Behaviour:
- Reset: reset is synchronous, active-high; clock is SDclock. All outputs, counters and latches are 0; state is IDLE.
- All outputs are registered: one SDclock of latency from the state or input that causes them.
- States: IDLE, CHECK, REQ, WAIT, NEXT, DONE.
- IDLE:
  - busy=0.
  - start=1 with block_count!=0: latch write_read, block_count, timeout_in and timeout_en_in; clear blocks_done and error_code; go to CHECK.
  - start=1 with block_count==0: pulse transfer_done with error_code=00; stay in IDLE.
- CHECK:
  - busy=1.
  - Advance to REQ only when phy_idle=1, and for a write fifo_empty=0, or for a read fifo_full=0. Otherwise wait indefinitely.
- REQ:
  - newService_control=1, held until phy_recibido=1, then go to WAIT.
  - An ack counter counts cycles in REQ. If it reaches ACK_LIMIT without phy_recibido: error_code=10, go to DONE.
- WAIT:
  - newService_control=0.
  - phy_complete=1: go to NEXT.
  - phy_timeout=1 (and phy_complete=0): error_code=01, go to DONE.
  - phy_complete and phy_timeout in the same cycle: completion wins.
- NEXT:
  - blocks_done increments by 1.
  - If the new value equals the latched count, go to DONE; else go to CHECK.
- DONE: transfer_done=1 for exactly one cycle, busy drops on the following cycle, then IDLE.
- abort=1 in any non-IDLE state: highest priority; error_code=11, newService_control=0, go to DONE.
- abort in IDLE is ignored.
- start while busy is ignored; latched values are unchanged.
- error_code and blocks_done hold until the next accepted start.
- blocks_done does not wrap: it never exceeds the latched count.
- Reset mid-transfer returns to IDLE with all reset values in the next cycle.

Decomposition:
- Shared package dat_pkg holds:
  - the state enum;
  - error-code constants ERR_NONE, ERR_DATA_TO, ERR_ACK_TO, ERR_ABORT;
  - default widths.
- Sub-module dat_block_counter: loadable up-counter with a terminal-count compare, used for blocks_done.

Test Plan:
- Write, block_count=3, fifo_empty=0, PHY acks after 2 cycles and completes after 10 -> three newService_control pulses; blocks_done=3; one transfer_done pulse; error_code=00.
- Read, block_count=2, fifo_full=1 for 20 cycles then 0 -> no newService_control while full; then completes; blocks_done=2.
- block_count=1, PHY never raises phy_recibido -> after 8 cycles in REQ: error_code=10, transfer_done pulse, blocks_done=0.
- block_count=4, phy_timeout on block 2 -> error_code=01, blocks_done=1, busy=0.
- phy_complete and phy_timeout high in the same cycle on last block of block_count=1 -> error_code=00, blocks_done=1.
- abort during WAIT of block 3 of 5 -> error_code=11, blocks_done=2; start pulse while busy earlier has no effect; reset mid-REQ -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dat_pkg.sv
// Shared types and constants for the DAT transfer control layer.
package dat_pkg;

  localparam int BLKCNT_W_DEF  = 16;
  localparam int TIMEOUT_W_DEF = 16;
  localparam int ACK_LIMIT_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } dat_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DATA_TO = 2'b01;
  localparam logic [1:0] ERR_ACK_TO  = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

endpackage

// File: rtl/dat_block_counter.sv
// Loadable block up-counter; flags when the next increment reaches the latched limit.
module dat_block_counter #(
  parameter int W = 16
) (
  input  logic         SDclock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] limit_q;

  always_ff @(posedge SDclock) begin
    if (reset) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      count   <= '0;
      limit_q <= limit;
    end else if (inc && (count != limit_q)) begin
      count <= count + W'(1);
    end
  end

  assign last = ((count + W'(1)) == limit_q);

endmodule

// File: rtl/dat_transfer_control.sv
// Multi-block DAT transfer sequencer: one newService_control handshake per block,
// gated on FIFO readiness, with ack/data timeout and abort reporting.
module dat_transfer_control
  import dat_pkg::*;
#(
  parameter int BLKCNT_W  = BLKCNT_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int ACK_LIMIT = ACK_LIMIT_DEF
) (
  input  logic                 SDclock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 write_read,
  input  logic [BLKCNT_W-1:0]  block_count,
  input  logic [TIMEOUT_W-1:0] timeout_in,
  input  logic                 timeout_en_in,
  input  logic                 abort,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  input  logic                 phy_idle,
  input  logic                 phy_recibido,
  input  logic                 phy_complete,
  input  logic                 phy_timeout,
  output logic                 newService_control,
  output logic                 writeRead_control,
  output logic [TIMEOUT_W-1:0] timeout,
  output logic                 timeoutenable,
  output logic                 busy,
  output logic                 transfer_done,
  output logic [1:0]           error_code,
  output logic [BLKCNT_W-1:0]  blocks_done
);

  localparam int ACK_W = $clog2(ACK_LIMIT + 1);

  dat_state_t       state, next_state;
  logic [ACK_W-1:0] ack_cnt;
  logic             accept, zero_req, cnt_inc, cnt_last, err_load;
  logic [1:0]       err_next;
  logic             fifo_ready;

  // Direction-dependent FIFO gate uses the latched direction.
  assign fifo_ready = writeRead_control ? !fifo_empty : !fifo_full;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    zero_req   = 1'b0;
    cnt_inc    = 1'b0;
    err_load   = 1'b0;
    err_next   = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (block_count != '0) begin
            accept     = 1'b1;
            next_state = ST_CHECK;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      ST_CHECK: if (phy_idle && fifo_ready) next_state = ST_REQ;
      ST_REQ: begin
        if (phy_recibido) begin
          next_state = ST_WAIT;
        end else if (ack_cnt == ACK_W'(ACK_LIMIT - 1)) begin
          next_state = ST_DONE;
          err_load   = 1'b1;
          err_next   = ERR_ACK_TO;
        end
      end
      ST_WAIT: begin
        if (phy_complete) begin
          next_state = ST_NEXT;
        end else if (phy_timeout) begin
          next_state = ST_DONE;
          err_load   = 1'b1;
          err_next   = ERR_DATA_TO;
        end
      end
      ST_NEXT: begin
        cnt_inc    = 1'b1;
        next_state = cnt_last ? ST_DONE : ST_CHECK;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    // Abort overrides everything while a transfer is active and not already finishing.
    if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
      next_state = ST_DONE;
      cnt_inc    = 1'b0;
      err_load   = 1'b1;
      err_next   = ERR_ABORT;
    end
  end

  always_ff @(posedge SDclock) begin
    if (reset) begin
      state   <= ST_IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= next_state;
      ack_cnt <= (state == ST_REQ) ? ack_cnt + ACK_W'(1) : '0;
    end
  end

  // Outputs are registered from the next-state decision, so they track the state register.
  always_ff @(posedge SDclock) begin
    if (reset) begin
      newService_control <= 1'b0;
      busy               <= 1'b0;
      transfer_done      <= 1'b0;
      error_code         <= ERR_NONE;
      writeRead_control  <= 1'b0;
      timeout            <= '0;
      timeoutenable      <= 1'b0;
    end else begin
      newService_control <= (next_state == ST_REQ);
      busy               <= (next_state != ST_IDLE);
      transfer_done      <= (next_state == ST_DONE) || zero_req;
      if (accept || zero_req) begin
        error_code <= ERR_NONE;
      end else if (err_load) begin
        error_code <= err_next;
      end
      if (accept) begin
        writeRead_control <= write_read;
        timeout           <= timeout_in;
        timeoutenable     <= timeout_en_in;
      end
    end
  end

  dat_block_counter #(
    .W(BLKCNT_W)
  ) u_blk_cnt (
    .SDclock(SDclock),
    .reset  (reset),
    .load   (accept || zero_req),
    .limit  (block_count),
    .inc    (cnt_inc),
    .count  (blocks_done),
    .last   (cnt_last)
  );

endmodule

// File: tb/tb_dat_transfer_control.sv
// Randomized bench for dat_transfer_control with a transaction-level reference model.
module tb_dat_transfer_control;

  localparam int BW     = 16;
  localparam int TW     = 16;
  localparam int AL     = 8;
  localparam int MAXB   = 8;
  localparam int MAXCYC = 3000;

  logic          SDclock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          write_read = 1'b0;
  logic [BW-1:0] block_count = '0;
  logic [TW-1:0] timeout_in = '0;
  logic          timeout_en_in = 1'b0;
  logic          abort = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          fifo_full = 1'b0;
  logic          phy_idle = 1'b1;
  logic          phy_recibido = 1'b0;
  logic          phy_complete = 1'b0;
  logic          phy_timeout = 1'b0;
  logic          newService_control, writeRead_control;
  logic [TW-1:0] timeout;
  logic          timeoutenable, busy, transfer_done;
  logic [1:0]    error_code;
  logic [BW-1:0] blocks_done;

  int checks = 0;
  int passed = 0;

  // Per-block PHY behaviour for the next transfer.
  int ack_dly[MAXB];   // REQ cycles before ack; >= AL means never
  int cmp_dly[MAXB];   // WAIT cycles before the PHY result
  int outc[MAXB];      // 0 complete, 1 data timeout, 2 both together
  int abort_blk;
  int fifo_hold;
  int busy_start_at;

  dat_transfer_control #(.BLKCNT_W(BW), .TIMEOUT_W(TW), .ACK_LIMIT(AL)) dut (
    .SDclock(SDclock), .reset(reset), .start(start), .write_read(write_read),
    .block_count(block_count), .timeout_in(timeout_in), .timeout_en_in(timeout_en_in),
    .abort(abort), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .phy_idle(phy_idle),
    .phy_recibido(phy_recibido), .phy_complete(phy_complete), .phy_timeout(phy_timeout),
    .newService_control(newService_control), .writeRead_control(writeRead_control),
    .timeout(timeout), .timeoutenable(timeoutenable), .busy(busy),
    .transfer_done(transfer_done), .error_code(error_code), .blocks_done(blocks_done)
  );

  always #5 SDclock = ~SDclock;

  task automatic cfg_default();
    for (int b = 0; b < MAXB; b++) begin
      ack_dly[b] = 2;
      cmp_dly[b] = $urandom_range(3, 12);
      outc[b]    = 0;
    end
    abort_blk     = -1;
    fifo_hold     = 0;
    busy_start_at = -1;
  endtask

  // Outcome of a transfer from the per-block PHY plan alone.
  function automatic void ref_model(input int n, output int exp_b, output logic [1:0] exp_e,
                                    output int exp_ns);
    exp_b = 0; exp_e = 2'b00; exp_ns = 0;
    for (int b = 0; b < n; b++) begin
      exp_ns++;
      if (ack_dly[b] >= AL) begin exp_e = 2'b10; return; end
      if (abort_blk == b)   begin exp_e = 2'b11; return; end
      if (outc[b] == 1)     begin exp_e = 2'b01; return; end
      exp_b++;
    end
  endfunction

  task automatic run_xfer(input string name, input bit wr, input int n,
                          input logic [TW-1:0] to, input bit toen);
    int ph, blk, pc, cyc, run, maxrun, nsp, exp_b, exp_ns;
    logic [1:0] exp_e;
    bit prev_ns, hold_viol, fin;
    ref_model(n, exp_b, exp_e, exp_ns);
    ph = 0; blk = 0; pc = 0; cyc = 0; run = 0; maxrun = 0; nsp = 0;
    prev_ns = 0; hold_viol = 0; fin = 0;
    @(negedge SDclock);
    start = 1; write_read = wr; block_count = BW'(n); timeout_in = to; timeout_en_in = toen;
    phy_idle = 1;
    if (wr) begin fifo_empty = (fifo_hold > 0); fifo_full = 1'($urandom_range(0, 1)); end
    else    begin fifo_full = (fifo_hold > 0); fifo_empty = 1'($urandom_range(0, 1)); end
    @(negedge SDclock);
    start = 0;
    checks++;
    if ({writeRead_control, timeout, timeoutenable, busy, error_code, blocks_done} !==
        {wr, to, toen, 1'b1, 2'b00, BW'(0)})
      $display("FAIL %s latch: wr=%0b to=%h ten=%0b busy=%0b err=%0b blk=%0d, expected wr=%0b to=%h ten=%0b busy=1 err=0 blk=0",
               name, writeRead_control, timeout, timeoutenable, busy, error_code, blocks_done, wr, to, toen);
    else passed++;
    while (cyc < MAXCYC) begin
      if (newService_control && !prev_ns) nsp++;
      run = newService_control ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      prev_ns = newService_control;
      if (newService_control && fifo_hold > 0 && cyc <= fifo_hold) hold_viol = 1;
      if (transfer_done) begin fin = 1; break; end
      phy_recibido = 0; phy_complete = 0; phy_timeout = 0; abort = 0; start = 0;
      if (cyc == fifo_hold) begin
        if (wr) fifo_empty = 0; else fifo_full = 0;
      end
      if (cyc == busy_start_at) begin
        start = 1; write_read = ~wr; block_count = BW'(n + 3); timeout_in = ~to; timeout_en_in = ~toen;
      end
      case (ph)
        0: begin
          phy_idle = ($urandom_range(0, 3) != 0);
          if (newService_control && blk < MAXB) begin
            if (pc == ack_dly[blk]) begin phy_recibido = 1; ph = 1; pc = 0; end
            else pc++;
          end
        end
        1: begin
          phy_idle = 1;
          pc++;
          if (abort_blk == blk && pc == 2) begin
            abort = 1; ph = 2;
          end else if (pc == cmp_dly[blk]) begin
            phy_complete = (outc[blk] != 1);
            phy_timeout  = (outc[blk] != 0);
            ph = (outc[blk] == 1) ? 2 : 0;
            blk++; pc = 0;
          end
        end
        default: ;
      endcase
      @(negedge SDclock);
      cyc++;
    end
    phy_recibido = 0; phy_complete = 0; phy_timeout = 0; abort = 0; start = 0; phy_idle = 1;
    checks++;
    if (!fin) $display("FAIL %s done_wait: no transfer_done within %0d cycles", name, MAXCYC);
    else passed++;
    checks++;
    if (error_code !== exp_e) $display("FAIL %s error_code: got %0b expected %0b", name, error_code, exp_e);
    else passed++;
    checks++;
    if (blocks_done !== BW'(exp_b)) $display("FAIL %s blocks_done: got %0d expected %0d", name, blocks_done, exp_b);
    else passed++;
    checks++;
    if (nsp !== exp_ns) $display("FAIL %s service_pulses: got %0d expected %0d", name, nsp, exp_ns);
    else passed++;
    checks++;
    if (maxrun > AL) $display("FAIL %s service_len: got %0d cycles, limit %0d", name, maxrun, AL);
    else passed++;
    if (fifo_hold > 0) begin
      checks++;
      if (hold_viol) $display("FAIL %s fifo_gate: newService_control=1 while FIFO blocked, expected 0", name);
      else passed++;
    end
    if (exp_e == 2'b10) begin
      checks++;
      if (maxrun !== AL) $display("FAIL %s ack_window: got %0d REQ cycles expected %0d", name, maxrun, AL);
      else passed++;
    end
    if (busy_start_at >= 0) begin
      checks++;
      if ({writeRead_control, timeout, timeoutenable} !== {wr, to, toen})
        $display("FAIL %s busy_start: wr=%0b to=%h ten=%0b expected wr=%0b to=%h ten=%0b",
                 name, writeRead_control, timeout, timeoutenable, wr, to, toen);
      else passed++;
    end
    @(negedge SDclock);
    checks++;
    if ({busy, transfer_done} !== 2'b00)
      $display("FAIL %s after_done: busy=%0b transfer_done=%0b expected 0 0", name, busy, transfer_done);
    else passed++;
    fifo_empty = 0; fifo_full = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge SDclock);
    checks++;
    if ({newService_control, writeRead_control, timeout, timeoutenable, busy, transfer_done,
         error_code, blocks_done} !== '0)
      $display("FAIL reset_state: outputs=%h expected 0", {newService_control, writeRead_control,
               timeout, timeoutenable, busy, transfer_done, error_code, blocks_done});
    else passed++;
    reset = 0;
    @(negedge SDclock);
    checks++;
    if ({busy, newService_control, transfer_done} !== 3'b000)
      $display("FAIL idle_after_reset: busy=%0b ns=%0b td=%0b expected 0 0 0", busy, newService_control, transfer_done);
    else passed++;
  endtask

  task automatic test_write_three();
    cfg_default();
    for (int b = 0; b < MAXB; b++) cmp_dly[b] = 10;
    run_xfer("write3", 1'b1, 3, 16'h0123, 1'b1);
  endtask

  task automatic test_read_fifo_full();
    logic [TW-1:0] to;
    cfg_default();
    fifo_hold = 20;
    to = TW'($urandom);
    run_xfer("read_fifo_full", 1'b0, 2, to, 1'b0);
  endtask

  task automatic test_ack_timeout();
    cfg_default();
    ack_dly[0] = AL - 1;
    run_xfer("ack_edge", 1'b1, 1, 16'h00FF, 1'b1);
    cfg_default();
    ack_dly[0] = AL;
    run_xfer("ack_timeout", 1'b1, 1, 16'h0F0F, 1'b0);
  endtask

  task automatic test_zero_count();
    @(negedge SDclock);
    start = 1; block_count = '0; write_read = 1;
    @(negedge SDclock);
    start = 0;
    checks++;
    if ({transfer_done, error_code, busy} !== 4'b1000)
      $display("FAIL zero_count: td=%0b err=%0b busy=%0b expected 1 00 0", transfer_done, error_code, busy);
    else passed++;
    @(negedge SDclock);
    checks++;
    if (transfer_done !== 1'b0) $display("FAIL zero_count_end: td=%0b expected 0", transfer_done);
    else passed++;
  endtask

  task automatic test_data_timeout();
    cfg_default();
    outc[1] = 1;
    run_xfer("data_timeout", 1'b0, 4, 16'h1234, 1'b1);
  endtask

  task automatic test_abort_idle();
    @(negedge SDclock);
    abort = 1;
    @(negedge SDclock);
    abort = 0;
    @(negedge SDclock);
    checks++;
    if ({busy, transfer_done, error_code} !== 4'b0001)
      $display("FAIL abort_idle: busy=%0b td=%0b err=%0b expected 0 0 01", busy, transfer_done, error_code);
    else passed++;
  endtask

  task automatic test_tie();
    cfg_default();
    outc[0] = 2;
    run_xfer("complete_timeout_tie", 1'b1, 1, 16'h0001, 1'b1);
  endtask

  task automatic test_abort_busy_start();
    cfg_default();
    abort_blk     = 2;
    cmp_dly[2]    = 8;
    busy_start_at = 3;
    run_xfer("abort_busy_start", 1'b1, 5, 16'hA5A5, 1'b1);
  endtask

  task automatic test_random();
    logic [TW-1:0] to;
    int n;
    bit wr;
    for (int t = 0; t < 10; t++) begin
      cfg_default();
      n  = $urandom_range(1, 6);
      wr = 1'($urandom_range(0, 1));
      to = TW'($urandom);
      for (int b = 0; b < MAXB; b++) begin
        ack_dly[b] = ($urandom_range(0, 9) == 0) ? AL : $urandom_range(0, AL - 1);
        case ($urandom_range(0, 9))
          7: outc[b] = 1;
          8: outc[b] = 2;
          default: outc[b] = 0;
        endcase
      end
      if ($urandom_range(0, 3) == 0) abort_blk = $urandom_range(0, n - 1);
      fifo_hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      if ($urandom_range(0, 1) == 1) busy_start_at = $urandom_range(1, 4);
      run_xfer($sformatf("random%0d", t), wr, n, to, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_ns(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (newService_control) begin ok = 1; break; end
      @(negedge SDclock);
    end
  endtask

  task automatic test_reset_mid_req();
    bit ok1, ok2;
    @(negedge SDclock);
    start = 1; write_read = 1; block_count = BW'(3); timeout_in = 16'hBEEF; timeout_en_in = 1;
    fifo_empty = 0; phy_idle = 1;
    @(negedge SDclock);
    start = 0;
    wait_ns(ok1);
    phy_recibido = 1;
    @(negedge SDclock);
    phy_recibido = 0; phy_complete = 1;
    @(negedge SDclock);
    phy_complete = 0;
    wait_ns(ok2);
    checks++;
    if (!(ok1 && ok2) || blocks_done !== BW'(1) || newService_control !== 1'b1)
      $display("FAIL pre_reset: req_seen=%0b/%0b blocks_done=%0d ns=%0b expected 1/1 1 1",
               ok1, ok2, blocks_done, newService_control);
    else passed++;
    reset = 1;
    @(negedge SDclock);
    checks++;
    if ({newService_control, writeRead_control, timeout, timeoutenable, busy, transfer_done,
         error_code, blocks_done} !== '0)
      $display("FAIL reset_mid_req: outputs=%h expected 0", {newService_control, writeRead_control,
               timeout, timeoutenable, busy, transfer_done, error_code, blocks_done});
    else passed++;
    reset = 0;
    @(negedge SDclock);
  endtask

  initial begin
    cfg_default();
    test_reset();
    test_write_three();
    test_read_fifo_full();
    test_ack_timeout();
    test_zero_count();
    test_data_timeout();
    test_abort_idle();
    test_tie();
    test_abort_busy_start();
    test_random();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
